// File: rtl/mem_responder_if.sv
// mem_responder_if: command/response bundle between the CPU memory port and
// mem_responder.
//
// Signals:
//   mem_cmd    [1:0]         00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal
//   mem_addr   [ADDR_W-1:0]  word address; the top bit must be 0 to select RAM
//   write_data [DATA_W-1:0]  store data, sampled when the command is accepted
//   read_data  [DATA_W-1:0]  registered read result
//   mem_ready                one-cycle completion pulse
//   busy                     an accepted access is in flight
//   err                      sticky bounds error (only with MEM_BOUNDS_CHECK_EN)
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN adds the err signal.
//
// Handshake: the master presents mem_cmd/mem_addr/write_data as a request.
// The responder accepts it on a rising edge only while idle. Every accepted
// access ends with exactly one mem_ready pulse. Requests seen while busy are
// dropped rather than queued, so the master may hold a command until it sees
// mem_ready without causing a second access.
interface mem_responder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
) ();
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              mem_ready;
   logic              busy;
`ifdef MEM_BOUNDS_CHECK_EN
   logic              err;

   modport master (
      output mem_cmd, mem_addr, write_data,
      input  read_data, mem_ready, busy, err
   );
   modport slave (
      input  mem_cmd, mem_addr, write_data,
      output read_data, mem_ready, busy, err
   );
`else
   modport master (
      output mem_cmd, mem_addr, write_data,
      input  read_data, mem_ready, busy
   );
   modport slave (
      input  mem_cmd, mem_addr, write_data,
      output read_data, mem_ready, busy
   );
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU mem_cmd bus. It services
// MREAD/MWRITE commands from a 2^RAM_AW x DATA_W synchronous RAM. Addresses
// with mem_addr[ADDR_W-1]==0 select the RAM. Each access completes with a
// one-cycle mem_ready pulse after WAIT_CYCLES extra wait states.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   bus        slave modport of mem_responder_if (cmd/addr/wdata in,
//              read_data/mem_ready/busy[/err] out)
//   state_dbg  out  current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN. When it is defined, bus.err is
// a sticky flag. It sets on an illegal or out-of-window command seen while
// idle, and only reset clears it.
module mem_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 9,
   parameter int RAM_AW      = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   mem_responder_if.slave   bus,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_ILL   = 2'b11;
   localparam logic [3:0] WAIT_CNT  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [RAM_AW-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   read_data_q;
   logic [DATA_W-1:0]   ram [0:(1<<RAM_AW)-1];

   logic cmd_rw;
   logic in_window;
   logic accept;
   logic commit;

   assign cmd_rw    = (bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE);
   assign in_window = ~bus.mem_addr[ADDR_W-1];
   assign accept    = (state_q == ST_IDLE) && cmd_rw && in_window;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               wr_d    = (bus.mem_cmd == CMD_WRITE);
               addr_d  = bus.mem_addr[RAM_AW-1:0];
               wdata_d = bus.write_data;
               cnt_d   = WAIT_CNT;
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The access commits on the edge that enters RESP. With no wait states this
   // is the acceptance edge itself. The *_d copies carry the live bus values on
   // that edge and the latched ones during WAIT, so one path serves both cases.
   assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (commit && !wr_d) read_data_q <= ram[addr_d];
      end
   end

   // The RAM has no reset. A reset on the commit edge must still block the store.
   always_ff @(posedge clk) begin
      if (!reset && commit && wr_d) ram[addr_d] <= wdata_d;
   end

`ifdef MEM_BOUNDS_CHECK_EN
   logic err_q;
   logic bad_cmd;

   assign bad_cmd = (state_q == ST_IDLE) &&
                    ((bus.mem_cmd == CMD_ILL) || (cmd_rw && !in_window));

   always_ff @(posedge clk) begin
      if (reset)        err_q <= 1'b0;
      else if (bad_cmd) err_q <= 1'b1;
   end

   assign bus.err = err_q;
`endif

   assign bus.read_data = read_data_q;
   assign bus.mem_ready = (state_q == ST_RESP);
   assign bus.busy      = (state_q != ST_IDLE);
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Two instances share one command stream: dut0
// has WAIT_CYCLES=0 and dut1 has WAIT_CYCLES=3. A transaction-level model
// (memory array plus last read value) predicts each completion. It pushes
// {ready_cycle, read_data} into a per-instance queue, and a negedge monitor
// pops and compares these entries. The monitor also checks busy each cycle
// against the predicted in-flight window.
module tb_mem_responder;

   localparam int NDUT = 2;
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;
   localparam logic [1:0] MILL   = 2'b11;

   logic        clk;
   logic        rst0, rst1;
   logic [1:0]  cmd;
   logic [8:0]  addr;
   logic [15:0] wdata;
   logic [1:0]  st0, st1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state
   logic [15:0] mem_m [256];
   logic [15:0] last_rd;
   logic        err_exp;
   int          bsy_lo [NDUT];
   int          bsy_hi [NDUT];
   int          wait_of [NDUT];
   logic [47:0] exp_q0[$];
   logic [47:0] exp_q1[$];

   mem_responder_if #(.DATA_W(16), .ADDR_W(9)) if0 ();
   mem_responder_if #(.DATA_W(16), .ADDR_W(9)) if1 ();

   assign if0.mem_cmd    = cmd;
   assign if0.mem_addr   = addr;
   assign if0.write_data = wdata;
   assign if1.mem_cmd    = cmd;
   assign if1.mem_addr   = addr;
   assign if1.write_data = wdata;

   mem_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(rst0), .bus(if0.slave), .state_dbg(st0)
   );
   mem_responder #(.WAIT_CYCLES(3)) dut1 (
      .clk(clk), .reset(rst1), .bus(if1.slave), .state_dbg(st1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_step(input int d, input logic rdy, input logic [15:0] rd, input logic bsy);
      logic [47:0] head;
      bit          have;
      logic        exp_bsy;
      head = '0;
      have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (have) head = (d == 0) ? exp_q0[0] : exp_q1[0];
      exp_bsy = (cyc >= bsy_lo[d]) && (cyc <= bsy_hi[d]);
      chk($sformatf("busy_dut%0d", d), 32'(bsy), 32'(exp_bsy));
      if (rdy) begin
         if (!have) begin
            total++;
            bad++;
            $display("FAIL ready_spurious_dut%0d: got mem_ready=1 expected 0 (cycle %0d)", d, cyc);
         end else begin
            if (d == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
            chk($sformatf("ready_cycle_dut%0d", d), 32'(cyc), head[47:16]);
            chk($sformatf("read_data_dut%0d", d), 32'(rd), 32'(head[15:0]));
         end
      end else if (have && (head[47:16] < 32'(cyc))) begin
         if (d == 0) void'(exp_q0.pop_front());
         else        void'(exp_q1.pop_front());
         total++;
         bad++;
         $display("FAIL ready_missing_dut%0d: got no mem_ready expected at cycle %0d", d, head[47:16]);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      mon_step(0, if0.mem_ready, if0.read_data, if0.busy);
      mon_step(1, if1.mem_ready, if1.read_data, if1.busy);
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_err(input string name);
`ifdef MEM_BOUNDS_CHECK_EN
      chk({name, "_dut0"}, 32'(if0.err), 32'(err_exp));
      chk({name, "_dut1"}, 32'(if1.err), 32'(err_exp));
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   // Present a command for 'hold' cycles (write data switches to wd2 in the
   // second cycle), then idle long enough for both instances to finish.
   task automatic issue(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd,
                        input int hold, input logic [15:0] wd2);
      int p;
      bit legal;
      p = cyc;
      cmd = c; addr = a; wdata = wd;
      legal = ((c == MREAD) || (c == MWRITE)) && !a[8];
      if (legal) begin
         for (int d = 0; d < NDUT; d++) begin
            bsy_lo[d] = p + 1;
            bsy_hi[d] = p + 1 + wait_of[d];
            if (d == 0) exp_q0.push_back({32'(p + 1 + wait_of[d]), (c == MREAD) ? mem_m[a[7:0]] : last_rd});
            else        exp_q1.push_back({32'(p + 1 + wait_of[d]), (c == MREAD) ? mem_m[a[7:0]] : last_rd});
         end
         if (c == MWRITE) mem_m[a[7:0]] = wd;
         else             last_rd = mem_m[a[7:0]];
      end else if (c != MNONE) begin
         err_exp = 1'b1;
      end
      step();
      if (!legal) begin
         chk("rd_hold_dut0", 32'(if0.read_data), 32'(last_rd));
         chk("rd_hold_dut1", 32'(if1.read_data), 32'(last_rd));
         check_err("err_after_cmd");
      end
      if (hold == 2) begin
         wdata = wd2;
         step();
      end
      cmd = MNONE;
      addr = 9'($urandom);
      wdata = 16'($urandom);
      repeat (6) step();
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      logic [15:0] rv;
      logic [1:0]  rc;
      logic [8:0]  ra;
      int          sel;
      wait_of[0] = 0;
      wait_of[1] = 3;
      for (int d = 0; d < NDUT; d++) begin
         bsy_lo[d] = 1;
         bsy_hi[d] = 0;
      end
      last_rd = 16'h0000;
      err_exp = 1'b0;
      cmd = MNONE; addr = '0; wdata = '0;
      rst0 = 1'b1; rst1 = 1'b1;
      repeat (3) step();
      rst0 = 1'b0; rst1 = 1'b0;

      // reset values
      chk("reset_read_data_dut0", 32'(if0.read_data), 32'h0);
      chk("reset_read_data_dut1", 32'(if1.read_data), 32'h0);
      chk("reset_ready_dut0", 32'(if0.mem_ready), 32'h0);
      chk("reset_ready_dut1", 32'(if1.mem_ready), 32'h0);
      check_err("reset_err");
      step();

      // preload a small address range so every later read is predictable
      for (int a = 0; a < 16; a++) issue(MWRITE, 9'(a), 16'($urandom), 1, 16'h0);

      // write then read back
      issue(MWRITE, 9'h005, 16'hABCD, 1, 16'h0);
      issue(MREAD,  9'h005, 16'h0,    1, 16'h0);

      // held commands: one access each, second-cycle write data ignored
      issue(MREAD,  9'h003, 16'h0,    2, 16'h0);
      issue(MWRITE, 9'h009, 16'h1234, 2, 16'hDEAD);
      issue(MREAD,  9'h009, 16'h0,    2, 16'h0);

      // out-of-window write must not touch ram[5]
      issue(MWRITE, 9'h105, 16'h1111, 1, 16'h0);
      repeat (10) step();
      check_err("err_sticky");
      issue(MREAD,  9'h005, 16'h0,    1, 16'h0);

      // illegal command
      issue(MILL,   9'h002, 16'h5555, 1, 16'h0);

      // randomized mix
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         ra  = 9'($urandom_range(0, 15));
         rv  = 16'($urandom);
         case (sel)
            0:       begin rc = ($urandom_range(0, 1) == 0) ? MREAD : MWRITE; ra[8] = 1'b1; end
            1:       rc = MILL;
            2:       rc = MNONE;
            3, 4, 5, 6: rc = MWRITE;
            default: rc = MREAD;
         endcase
         issue(rc, ra, rv, $urandom_range(1, 2), ~rv);
      end

      // reset on the commit edge
      issue(MWRITE, 9'h007, 16'h0001, 1, 16'h0);
      begin
         int p;
         p = cyc;
         cmd = MWRITE; addr = 9'h007; wdata = 16'h2222;
         rst0 = 1'b1;             // dut0 commits on the acceptance edge
         bsy_lo[1] = p + 1;       // dut1 accepts, then is reset on its commit edge
         bsy_hi[1] = p + 3;
         step();
         cmd = MNONE; rst0 = 1'b0;
         step();
         step();
         rst1 = 1'b1;
         step();
         rst1 = 1'b0;
         last_rd = 16'h0000;
         err_exp = 1'b0;
         chk("rst_commit_rd_dut0", 32'(if0.read_data), 32'h0);
         chk("rst_commit_rd_dut1", 32'(if1.read_data), 32'h0);
         chk("rst_commit_ready_dut1", 32'(if1.mem_ready), 32'h0);
         chk("rst_commit_busy_dut1", 32'(if1.busy), 32'h0);
         check_err("rst_commit_err");
         repeat (4) step();
      end
      issue(MREAD, 9'h007, 16'h0, 1, 16'h0);

      repeat (4) step();
      chk("queue_empty_dut0", 32'(exp_q0.size()), 32'h0);
      chk("queue_empty_dut1", 32'(exp_q1.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
